// File: rtl/dnn_pkg.sv
// rtl/dnn_pkg.sv - shared state encoding and arithmetic helpers for the sequential dense layer
package dnn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Working width for the clip helper; wide enough for any accumulator in use.
    localparam int SAT_W = 64;

    // Full-width product plus enough headroom that N_IN of them cannot overflow.
    function automatic int acc_width(input int in_size, input int n_in);
        return 2 * in_size + $clog2(n_in);
    endfunction

    // Clamp a signed value into the range of an out_size-bit signed number.
    function automatic logic signed [SAT_W-1:0] sat_clip(
        input  logic signed [SAT_W-1:0] value,
        input  int                      out_size,
        output logic                    clipped
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (out_size - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        clipped  = 1'b0;
        sat_clip = value;
        if (value > hi) begin
            sat_clip = hi;
            clipped  = 1'b1;
        end else if (value < lo) begin
            sat_clip = lo;
            clipped  = 1'b1;
        end
    endfunction

endpackage

// File: rtl/dnn_layer_seq_if.sv
// rtl/dnn_layer_seq_if.sv - operand/result bundle between a layer stage and its neighbours
// Ports (master drives): in_ready, relu_en, x_flat, w_flat
// Ports (slave drives):  out_flat, mac_ready, busy, sat_flag
interface dnn_layer_seq_if #(
    parameter int IN_SIZE  = 7,
    parameter int OUT_SIZE = 17,
    parameter int N_IN     = 4,
    parameter int N_OUT    = 4
);
    logic                            in_ready;
    logic                            relu_en;
    logic [N_IN*IN_SIZE-1:0]         x_flat;
    logic [N_IN*N_OUT*IN_SIZE-1:0]   w_flat;
    logic [N_OUT*OUT_SIZE-1:0]       out_flat;
    logic                            mac_ready;
    logic                            busy;
    logic                            sat_flag;

    modport master (
        output in_ready, relu_en, x_flat, w_flat,
        input  out_flat, mac_ready, busy, sat_flag
    );

    modport slave (
        input  in_ready, relu_en, x_flat, w_flat,
        output out_flat, mac_ready, busy, sat_flag
    );
endinterface

// File: rtl/dnn_mac_lane.sv
// rtl/dnn_mac_lane.sv - one output neuron: signed multiply-accumulate plus ReLU/saturate stage
// Ports: clk, rst (sync, active-high); clr zeroes the accumulator; en adds x*w;
//        load registers the post-processed accumulator into result/clip; relu_en selects ReLU.
module dnn_mac_lane
    import dnn_pkg::*;
#(
    parameter int IN_SIZE  = 7,
    parameter int OUT_SIZE = 17,
    parameter int N_IN     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       en,
    input  logic                       load,
    input  logic                       relu_en,
    input  logic signed [IN_SIZE-1:0]  x,
    input  logic signed [IN_SIZE-1:0]  w,
    output logic signed [OUT_SIZE-1:0] result,
    output logic                       clip
);
    localparam int ACC_W  = acc_width(IN_SIZE, N_IN);
    localparam int PROD_W = 2 * IN_SIZE;

    logic signed [ACC_W-1:0]  acc;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [SAT_W-1:0]  relu_val;
    logic signed [SAT_W-1:0]  sat_val;
    logic                     sat_hit;

    assign prod     = PROD_W'(x) * PROD_W'(w);
    assign prod_ext = ACC_W'(prod);

    always_comb begin
        relu_val = SAT_W'(acc);
        if (relu_en && (acc < 0)) begin
            relu_val = '0;
        end
        sat_val = sat_clip(relu_val, OUT_SIZE, sat_hit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + prod_ext;
        end
    end

    // result and clip only move on load, so they hold between computations.
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            clip   <= 1'b0;
        end else if (load) begin
            result <= OUT_SIZE'(sat_val);
            clip   <= sat_hit;
        end
    end
endmodule

// File: rtl/dnn_layer_seq.sv
// rtl/dnn_layer_seq.sv - time-multiplexed fully-connected layer, one multiplier per output lane
// Ports: clk, rst (sync, active-high), bus (slave side of dnn_layer_seq_if):
//        in_ready/relu_en/x_flat/w_flat in; out_flat/mac_ready/busy/sat_flag out.
module dnn_layer_seq
    import dnn_pkg::*;
#(
    parameter int IN_SIZE  = 7,
    parameter int OUT_SIZE = 17,
    parameter int N_IN     = 4,
    parameter int N_OUT    = 4
) (
    input  logic            clk,
    input  logic            rst,
    dnn_layer_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(N_IN);

    state_t                          state_q;
    state_t                          state_d;
    logic [CNT_W-1:0]                cnt;
    logic [N_IN*IN_SIZE-1:0]         x_reg;
    logic [N_IN*N_OUT*IN_SIZE-1:0]   w_reg;
    logic                            relu_reg;
    logic                            mac_ready_q;
    logic                            clr;
    logic                            en;
    logic                            load;
    logic                            last;
    logic signed [IN_SIZE-1:0]       x_sel;
    logic [N_OUT-1:0]                clip;
    logic [N_OUT*OUT_SIZE-1:0]       out_all;

    assign last  = (cnt == CNT_W'(N_IN - 1));
    assign x_sel = x_reg[32'(cnt)*IN_SIZE +: IN_SIZE];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt         <= '0;
            x_reg       <= '0;
            w_reg       <= '0;
            relu_reg    <= 1'b0;
            mac_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mac_ready_q <= load;
            // Operands are captured at accept so upstream may move on immediately.
            if (clr) begin
                cnt      <= '0;
                x_reg    <= bus.x_flat;
                w_reg    <= bus.w_flat;
                relu_reg <= bus.relu_en;
            end else if (en) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        en      = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_ready) begin
                    clr     = 1'b1;
                    state_d = ACC;
                end
            end
            ACC: begin
                en = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                load    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_lane
        logic signed [IN_SIZE-1:0] w_sel;
        assign w_sel = w_reg[(32'(cnt)*N_OUT + j)*IN_SIZE +: IN_SIZE];

        dnn_mac_lane #(
            .IN_SIZE (IN_SIZE),
            .OUT_SIZE(OUT_SIZE),
            .N_IN    (N_IN)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr),
            .en     (en),
            .load   (load),
            .relu_en(relu_reg),
            .x      (x_sel),
            .w      (w_sel),
            .result (out_all[j*OUT_SIZE +: OUT_SIZE]),
            .clip   (clip[j])
        );
    end

    assign bus.out_flat  = out_all;
    assign bus.mac_ready = mac_ready_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.sat_flag  = |clip;
endmodule

// File: tb/tb_dnn_layer_seq.sv
// tb/tb_dnn_layer_seq.sv - directed self-checking bench for dnn_layer_seq
module tb_dnn_layer_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    dnn_layer_seq_if                  if0();
    dnn_layer_seq_if #(.OUT_SIZE(12)) if1();

    dnn_layer_seq                  u0 (.clk(clk), .rst(rst), .bus(if0));
    dnn_layer_seq #(.OUT_SIZE(12)) u1 (.clk(clk), .rst(rst), .bus(if1));

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [63:0] lane(input bit u, input int j);
        if (u) return $signed(if1.out_flat[j*12 +: 12]);
        return $signed(if0.out_flat[j*17 +: 17]);
    endfunction

    // x(i) = x0..x3; w(i,j) = wj for every i (one weight per output column)
    task automatic set_ops(input bit u, input int x0, input int x1, input int x2, input int x3,
                           input int w0, input int w1, input int w2, input int w3, input bit relu);
        logic [27:0]  xf;
        logic [111:0] wf;
        int xv[4];
        int wv[4];
        xv[0] = x0; xv[1] = x1; xv[2] = x2; xv[3] = x3;
        wv[0] = w0; wv[1] = w1; wv[2] = w2; wv[3] = w3;
        for (int i = 0; i < 4; i++) begin
            xf[i*7 +: 7] = 7'(xv[i]);
            for (int j = 0; j < 4; j++) wf[(i*4+j)*7 +: 7] = 7'(wv[j]);
        end
        if (u) begin
            if1.x_flat = xf; if1.w_flat = wf; if1.relu_en = relu;
        end else begin
            if0.x_flat = xf; if0.w_flat = wf; if0.relu_en = relu;
        end
    endtask

    // Accept, scramble the ports (operands must already be latched), wait for mac_ready.
    task automatic run(input bit u);
        int lat;
        if (u) if1.in_ready = 1'b1; else if0.in_ready = 1'b1;
        step();
        if0.in_ready = 1'b0; if1.in_ready = 1'b0;
        if0.x_flat = ~if0.x_flat; if0.w_flat = ~if0.w_flat; if0.relu_en = ~if0.relu_en;
        if1.x_flat = ~if1.x_flat; if1.w_flat = ~if1.w_flat; if1.relu_en = ~if1.relu_en;
        lat = 0;
        while (((u ? if1.mac_ready : if0.mac_ready) !== 1'b1) && lat < 20) begin
            step();
            lat++;
        end
        check("latency", lat, 5);
    endtask

    initial begin
        int pulses;
        int lat;
        if0.in_ready = 1'b0; if1.in_ready = 1'b0;
        set_ops(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_ops(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        rst = 1'b0;
        check("rst_busy", if0.busy, 0);
        check("rst_mac", if0.mac_ready, 0);
        check("rst_out", |if0.out_flat, 0);
        check("rst_sat", if0.sat_flag, 0);
        check("rst_busy12", if1.busy, 0);
        check("rst_out12", |if1.out_flat, 0);

        // Basic sum with cycle-exact busy/mac_ready
        set_ops(0, 1, 2, 3, 4, 1, 1, 1, 1, 0);
        if0.in_ready = 1'b1;
        step();
        if0.in_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("t1_busy", if0.busy, 1);
            check("t1_mac_lo", if0.mac_ready, 0);
            step();
        end
        check("t1_mac", if0.mac_ready, 1);
        check("t1_busy_done", if0.busy, 0);
        for (int j = 0; j < 4; j++) check("t1_out", lane(0, j), 10);
        check("t1_sat", if0.sat_flag, 0);
        step();
        check("t1_mac_pulse", if0.mac_ready, 0);
        check("t1_hold", lane(0, 2), 10);

        // Extreme negative inputs, no ReLU
        set_ops(0, -64, -64, -64, -64, 63, -64, 0, 0, 0);
        run(0);
        check("t2_out0", lane(0, 0), -16128);
        check("t2_out1", lane(0, 1), 16384);
        check("t2_out2", lane(0, 2), 0);
        check("t2_sat", if0.sat_flag, 0);

        // Same with ReLU
        set_ops(0, -64, -64, -64, -64, 63, -64, 0, 0, 1);
        run(0);
        check("t3_out0", lane(0, 0), 0);
        check("t3_out1", lane(0, 1), 16384);

        // Narrow output: positive and negative clipping, then back in range
        set_ops(1, 63, 63, 63, 63, 63, 63, 63, 63, 0);
        run(1);
        for (int j = 0; j < 4; j++) check("t4_clip_hi", lane(1, j), 2047);
        check("t4_sat", if1.sat_flag, 1);
        set_ops(1, -64, -64, -64, -64, 63, 63, 63, 63, 0);
        run(1);
        check("t4_clip_lo", lane(1, 3), -2048);
        check("t4_sat_lo", if1.sat_flag, 1);
        set_ops(1, 1, 1, 1, 1, 1, 1, 1, 1, 0);
        run(1);
        check("t4_small", lane(1, 0), 4);
        check("t4_small3", lane(1, 3), 4);
        check("t4_sat_clr", if1.sat_flag, 0);

        // in_ready during ACC is ignored; in_ready right after mac_ready is accepted
        set_ops(0, 1, 2, 3, 4, 1, 1, 1, 1, 0);
        if0.in_ready = 1'b1;
        step();
        if0.in_ready = 1'b0;
        step();
        set_ops(0, 5, 5, 5, 5, 2, 2, 2, 2, 0);
        if0.in_ready = 1'b1;
        step();
        if0.in_ready = 1'b0;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (if0.mac_ready === 1'b1) pulses++;
        end
        check("t5_pulses", pulses, 1);
        check("t5_mac_c5", if0.mac_ready, 1);
        check("t5_out", lane(0, 1), 10);
        set_ops(0, 2, 2, 2, 2, 1, 1, 1, 1, 0);
        if0.in_ready = 1'b1;
        step();
        if0.in_ready = 1'b0;
        lat = 0;
        while (if0.mac_ready !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        check("t5_second_lat", lat, 5);
        check("t5_second_out", lane(0, 3), 8);

        // Reset mid-computation aborts it
        set_ops(0, 1, 2, 3, 4, 1, 1, 1, 1, 0);
        if0.in_ready = 1'b1;
        step();
        if0.in_ready = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_busy", if0.busy, 0);
        check("t6_out", |if0.out_flat, 0);
        check("t6_mac", if0.mac_ready, 0);
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (if0.mac_ready === 1'b1) pulses++;
        end
        check("t6_no_pulse", pulses, 0);
        set_ops(0, 1, 2, 3, 4, 1, 2, 3, 4, 0);
        run(0);
        check("t6_out0", lane(0, 0), 10);
        check("t6_out1", lane(0, 1), 20);
        check("t6_out2", lane(0, 2), 30);
        check("t6_out3", lane(0, 3), 40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
